// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - chunk-serial two's-complement adder/subtractor with valid/ready handshake
// Processes CHUNK bits per cycle, LSB chunk first, carrying between chunks.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_chk;
  logic [CHUNK-1:0] w_b_chk;
  logic [CHUNK:0]   w_sum_full;
  logic             w_msb_cin;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_place;

  // Operands shift right each BUSY cycle, so the low chunk is always the one in flight.
  assign w_a_chk     = r_a[CHUNK-1:0];
  assign w_b_chk     = r_b[CHUNK-1:0] ^ {CHUNK{r_op}};
  assign w_sum_full  = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};
  assign w_msb_cin   = w_sum_full[CHUNK-1] ^ w_a_chk[CHUNK-1] ^ w_b_chk[CHUNK-1];
  assign w_last      = (r_cnt == CNT_W'(NCHUNK - 1));
  assign w_sum_place = WIDTH'(w_sum_full[CHUNK-1:0]) << (WIDTH - CHUNK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            r_carry <= op;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            // Result fills from the top; after NCHUNK shifts the old value is fully replaced.
            r_result <= (r_result >> CHUNK) | w_sum_place;
            r_a      <= r_a >> CHUNK;
            r_b      <= r_b >> CHUNK;
            r_carry  <= w_sum_full[CHUNK];
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
              r_cout  <= w_sum_full[CHUNK];
              r_ovf   <= w_msb_cin ^ w_sum_full[CHUNK];
              r_cnt   <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (abort || out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = (r_result == '0);
  assign negative  = r_result[WIDTH-1];

endmodule
